// File: rtl/mips8_pkg.sv
// Shared types and constants for the mips8 pad loader: command encoding,
// loader FSM states and the bit layout of the host pad bus.
package mips8_pkg;

  localparam int PAD_W        = 16;
  localparam int PAD_BYTE_LSB = 0;
  localparam int PAD_BYTE_W   = 8;
  localparam int PAD_CMD_LSB  = 8;
  localparam int PAD_CMD_W    = 2;
  localparam int PAD_STB_BIT  = 15;

  typedef enum logic [PAD_CMD_W-1:0] {
    CMD_WRITE   = 2'b00,
    CMD_SETADDR = 2'b01,
    CMD_RUN     = 2'b10,
    CMD_HALT    = 2'b11
  } cmd_e;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  // Packed so that {cmd, byte} on the pad bus maps straight onto an entry.
  typedef struct packed {
    cmd_e                  cmd;
    logic [PAD_BYTE_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/mips8_pad_loader_if.sv
// Instruction-memory write handshake between the pad loader and the core.
interface mips8_pad_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) ();

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output addr, output data, output valid, input ready);
  modport slave  (input addr, input data, input valid, output ready);

endinterface

// File: rtl/mips8_cmd_fifo.sv
// Small synchronous FIFO for host commands; push is ignored when full and
// pop is ignored when empty, so full/empty reflect the pre-update occupancy.
module mips8_cmd_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign push_ok   = push_i & ~full_o;
  assign pop_ok    = pop_i & ~empty_o;

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; a slot is only read after a push has filled it.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/mips8_pad_loader.sv
// Pad-side program loader: synchronises host strobes from the pads, queues
// commands and replays them as instruction-memory writes and core reset control.
module mips8_pad_loader
  import mips8_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [PAD_W-1:0]      pad_in,
  output logic                  pad_ack_o,
  output logic                  pad_ovf_o,
  mips8_pad_loader_if.master    imem,
  output logic                  core_rst_o,
  output logic                  busy_o
);

  localparam int ENTRY_W = $bits(entry_t);

  logic [PAD_W-1:0]        sync1_q, sync2_q;
  logic                    stb3_q;
  logic                    stb_rise;
  logic                    unused_pad_bits;
  entry_t                  pad_entry;

  logic                    ack_q, ovf_q;
  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]      fifo_rd;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  entry_t                  head;

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic                    core_rst_q, core_rst_d;

  // Two-flop synchroniser on the whole bus plus a third flop for strobe edge detect.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      stb3_q  <= 1'b0;
    end else begin
      sync1_q <= pad_in;
      sync2_q <= sync1_q;
      stb3_q  <= sync2_q[PAD_STB_BIT];
    end
  end

  assign stb_rise        = sync2_q[PAD_STB_BIT] & ~stb3_q;
  assign pad_entry       = entry_t'(sync2_q[PAD_CMD_LSB+PAD_CMD_W-1:PAD_BYTE_LSB]);
  assign unused_pad_bits = ^sync2_q[PAD_STB_BIT-1:PAD_CMD_LSB+PAD_CMD_W];
  assign fifo_push       = stb_rise & ~fifo_full;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      ack_q <= ack_q ^ fifo_push;
      ovf_q <= ovf_q | (stb_rise & fifo_full);
    end
  end

  mips8_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (wb_clk_i),
    .rst_i     (wb_rst_i),
    .push_i    (fifo_push),
    .wr_data_i (pad_entry),
    .pop_i     (fifo_pop),
    .rd_data_o (fifo_rd),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign head = entry_t'(fifo_rd);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      core_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      core_rst_q <= core_rst_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    core_rst_d = core_rst_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          case (head.cmd)
            CMD_WRITE: begin
              data_d  = DATA_W'(head.data);
              state_d = WRITE;
            end
            CMD_SETADDR: addr_d     = ADDR_W'(head.data);
            CMD_RUN:     core_rst_d = 1'b0;
            CMD_HALT:    core_rst_d = 1'b1;
          endcase
        end
      end
      WRITE: begin
        // Address advances only after the handshake, so it is stable under valid.
        if (imem.ready) begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    fifo_pop   = (state_q == IDLE) & ~fifo_empty;
    imem.valid = (state_q == WRITE);
    busy_o     = (fifo_count != '0) | (state_q == WRITE);
  end

  assign imem.addr  = addr_q;
  assign imem.data  = data_q;
  assign pad_ack_o  = ack_q;
  assign pad_ovf_o  = ovf_q;
  assign core_rst_o = core_rst_q;

endmodule

// File: tb/tb_mips8_pad_loader.sv
// Directed bench for mips8_pad_loader: expected memory writes go into a
// scoreboard queue and a negedge monitor checks every handshake against it.
module tb_mips8_pad_loader;

  logic        clk;
  logic        rst;
  logic [15:0] pad;
  logic        pad_ack, pad_ovf, core_rst, busy;

  mips8_pad_loader_if #(.ADDR_W(8), .DATA_W(8)) imem_if ();

  mips8_pad_loader #(
    .DATA_W     (8),
    .ADDR_W     (8),
    .FIFO_DEPTH (4)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .pad_in     (pad),
    .pad_ack_o  (pad_ack),
    .pad_ovf_o  (pad_ovf),
    .imem       (imem_if),
    .core_rst_o (core_rst),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          hs_count = 0;
  int          ack_toggles = 0;
  logic [15:0] exp_q [$];
  logic [7:0]  model_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Host protocol: byte/cmd set up 3 cycles before the strobe and held throughout.
  task automatic send(input logic [1:0] cmd, input logic [7:0] b);
    pad = {1'b0, 5'h15, cmd, b};
    tick(3);
    pad[15] = 1'b1;
    tick(4);
    pad[15] = 1'b0;
    tick(4);
  endtask

  task automatic issue_write(input logic [7:0] b);
    exp_q.push_back({model_addr, b});
    model_addr = model_addr + 8'd1;
    send(2'b00, b);
  endtask

  task automatic issue_setaddr(input logic [7:0] b);
    model_addr = b;
    send(2'b01, b);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && (busy || exp_q.size() != 0); i++) tick(1);
    check(name, (busy === 1'b1 || exp_q.size() != 0), 0);
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 100 && imem_if.valid !== 1'b1; i++) tick(1);
    check(name, imem_if.valid, 1);
  endtask

  // Monitor: handshakes against the scoreboard, and hold stability during stalls.
  logic       stall_v = 1'b0;
  logic [7:0] stall_addr, stall_data;
  logic       ack_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      stall_v = 1'b0;
    end else begin
      if (stall_v) begin
        check("hold_valid", imem_if.valid, 1);
        check("hold_addr", imem_if.addr, stall_addr);
        check("hold_data", imem_if.data, stall_data);
      end
      if (imem_if.valid && imem_if.ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                   imem_if.addr, imem_if.data);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          check("write_addr", imem_if.addr, e[15:8]);
          check("write_data", imem_if.data, e[7:0]);
        end
        hs_count++;
      end
      stall_v    = imem_if.valid && !imem_if.ready;
      stall_addr = imem_if.addr;
      stall_data = imem_if.data;
    end
    if (pad_ack !== ack_prev) ack_toggles++;
    ack_prev = pad_ack;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int vcount;
    int rcount;
    int ack_start;
    int hs_before;

    rst = 1'b1;
    pad = '0;
    imem_if.ready = 1'b0;
    model_addr = 8'h00;
    tick(3);

    // Reset values.
    check("rst_ack", pad_ack, 0);
    check("rst_ovf", pad_ovf, 0);
    check("rst_addr", imem_if.addr, 0);
    check("rst_data", imem_if.data, 0);
    check("rst_valid", imem_if.valid, 0);
    check("rst_core_rst", core_rst, 1);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    vcount = 0;
    rcount = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (imem_if.valid) vcount++;
      if (!core_rst) rcount++;
    end
    check("idle_no_valid", vcount, 0);
    check("idle_core_held", rcount, 0);

    // Basic writes with ready held high.
    imem_if.ready = 1'b1;
    ack_start = ack_toggles;
    issue_setaddr(8'h10);
    issue_write(8'hA5);
    issue_write(8'h3C);
    drain("drain_basic");
    check("ack_toggles_basic", ack_toggles - ack_start, 3);
    check("ack_level_basic", pad_ack, 1);

    // Address wrap 0xFF -> 0x00.
    issue_setaddr(8'hFF);
    issue_write(8'h01);
    issue_write(8'h02);
    drain("drain_wrap");
    check("addr_after_wrap", imem_if.addr, 8'h01);

    // Stall for 20 cycles; the monitor checks that the request holds.
    imem_if.ready = 1'b0;
    issue_write(8'h77);
    wait_valid("stall_valid_seen");
    tick(20);
    check("stall_valid", imem_if.valid, 1);
    check("stall_addr", imem_if.addr, 8'h01);
    check("stall_data", imem_if.data, 8'h77);
    imem_if.ready = 1'b1;
    tick(1);
    check("stall_done_valid", imem_if.valid, 0);
    check("stall_done_addr", imem_if.addr, 8'h02);

    // Overflow: one entry in flight, four queued, sixth strobe dropped.
    imem_if.ready = 1'b0;
    ack_start = ack_toggles;
    for (int i = 0; i < 5; i++) issue_write(8'h10 + 8'(i));
    send(2'b00, 8'h15);
    check("ovf_set", pad_ovf, 1);
    check("ovf_ack_toggles", ack_toggles - ack_start, 5);
    check("ovf_busy", busy, 1);
    imem_if.ready = 1'b1;
    drain("drain_ovf");
    check("ovf_sticky", pad_ovf, 1);
    check("addr_after_ovf", imem_if.addr, 8'h07);

    // RUN queued behind two writes releases the core only after both complete.
    imem_if.ready = 1'b0;
    issue_write(8'h88);
    issue_write(8'h99);
    send(2'b10, 8'h00);
    tick(5);
    check("run_held_while_stalled", core_rst, 1);
    hs_before = hs_count;
    imem_if.ready = 1'b1;
    for (int i = 0; i < 50 && core_rst !== 1'b0; i++) tick(1);
    check("run_released", core_rst, 0);
    check("run_after_writes", hs_count - hs_before, 2);
    drain("drain_run");

    // Reset in the middle of a stalled write.
    imem_if.ready = 1'b0;
    issue_write(8'h5A);
    wait_valid("midrst_valid_seen");
    rst = 1'b1;
    #1;
    check("midrst_valid", imem_if.valid, 0);
    check("midrst_core_rst", core_rst, 1);
    check("midrst_ovf", pad_ovf, 0);
    check("midrst_busy", busy, 0);
    check("midrst_addr", imem_if.addr, 0);
    exp_q.delete();
    tick(2);
    rst = 1'b0;
    tick(5);
    check("post_rst_idle", imem_if.valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips8_pad_loader.md
# mips8_pad_loader

- Pad-side program loader between the chip's user IO inputs and the mips8 core.
- Samples a 16-bit asynchronous pad bus (host-driven strobe, command and byte) and synchronises it into the `wb_clk_i` domain.
- Buffers commands in a small FIFO and drives the core's instruction-memory write handshake with an auto-incrementing address.
- Holds the core in reset until the host issues a run command; feeds the core directly upstream, in place of raw pads.

## Interface
- `DATA_W`, 8, instruction/data byte width
- `ADDR_W`, 8, instruction-memory address width
- `FIFO_DEPTH`, 4, command FIFO entries (power of two, ≥2)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `wb_clk_i`  in  1  system clock
  - `wb_rst_i`  in  1  asynchronous active-high reset
- `pad_in`  in  16  raw pad inputs (asynchronous):
  - [7:0] byte
  - [9:8] cmd
  - [14:10] ignored
  - [15] strobe
- `pad_ack_o`  out  1  toggles once per accepted strobe
- `pad_ovf_o`  out  1  sticky overflow (strobe dropped, FIFO full)
- `imem_addr_o`  out  ADDR_W  write address
- `imem_data_o`  out  DATA_W  write data
- `imem_valid_o`  out  1  write request
- `imem_ready_i`  in  1  memory accepts write
- `core_rst_o`  out  1  core reset hold, active-high
- `busy_o`  out  1  FIFO non-empty or write in flight

## Operation
- All 16 pad bits pass a 2-flop synchroniser. A third flop on bit 15 gives rising-edge detect: `stb_rise = s2[15] & ~s3`.
- On `stb_rise`, push {cmd, byte} from the synchronised stage 2 into the FIFO:
  - if occupancy == `FIFO_DEPTH` (pre-pop count, even if a pop occurs the same cycle), drop the entry and set `pad_ovf_o`;
  - otherwise push and toggle `pad_ack_o`.
- `pad_ovf_o` clears only on reset.
- Commands:
  - 00 WRITE: write byte at the current address, then address +1, wrapping 255→0.
  - 01 SETADDR: address ← byte.
  - 10 RUN: `core_rst_o` ← 0.
  - 11 HALT: `core_rst_o` ← 1.
- FSM states `IDLE`, `WRITE`:
  - IDLE, FIFO empty: stay.
  - IDLE, FIFO non-empty: pop the head entry in this cycle.
    - SETADDR/RUN/HALT execute in this cycle; stay in IDLE.
    - WRITE latches `imem_data_o` ← byte and goes to WRITE.
  - WRITE: `imem_valid_o` = 1. Address and data are stable while valid is high.
    - `imem_ready_i` = 1: the transfer completes this cycle; next cycle address +1 and return to IDLE.
    - `imem_ready_i` = 0: stay in WRITE indefinitely.
- Commands execute strictly in FIFO order. A RUN queued behind WRITEs releases the core only after those writes complete.
- `busy_o` = (occupancy ≠ 0) | (state == WRITE).
- Reset at any time, including mid-WRITE, leaves the block in the reset state below. The in-flight write is abandoned; the memory must tolerate a `valid` withdrawal caused by reset.

## Timing
- Reset values:
  - `pad_ack_o`=0, `pad_ovf_o`=0
  - `imem_addr_o`=0, `imem_data_o`=0, `imem_valid_o`=0
  - `core_rst_o`=1, `busy_o`=0
  - FSM=IDLE, FIFO empty, synchroniser flops 0.
- Host rules:
  - Byte and cmd stable ≥3 cycles before and after the strobe rise.
  - Strobe high ≥3 and low ≥3 cycles.
- Latencies:
  - Pad strobe rise → push: 3 cycles.
  - Push → pop: ≥1 cycle.
  - Pop of WRITE → `imem_valid_o` high: 1 cycle.
  - Minimum two cycles per write with `imem_ready_i` held high.
- `pad_ack_o` toggles in the cycle after the push.
- Pop and push in the same cycle on a non-full FIFO: both occur, and occupancy is unchanged.

## Structure
- Shared package `mips8_pkg`:
  - command enum (`CMD_WRITE`, `CMD_SETADDR`, `CMD_RUN`, `CMD_HALT`)
  - FSM state enum
  - pad bit-position constants
- One sub-module `mips8_cmd_fifo`: parameterised synchronous FIFO with push/pop/full/empty/count.
- The synchroniser and FSM live in the top level.

## Test plan
- Reset then idle → all outputs at their reset values, `core_rst_o`=1, no `imem_valid_o` for 100 cycles.
- SETADDR 0x10, WRITE 0xA5, WRITE 0x3C with `imem_ready_i`=1:
  - writes (0x10,0xA5) and (0x11,0x3C);
  - `pad_ack_o` toggles 3 times, ending at 1.
- SETADDR 0xFF, WRITE 0x01, WRITE 0x02 → writes at 0xFF then 0x00 (wrap).
- `imem_ready_i`=0 for 20 cycles during a WRITE → `imem_valid_o`, address and data held constant; completes one cycle after ready rises.
- Ready held low while 6 strobes are sent:
  - first entry popped, then 4 queued, 6th dropped;
  - `pad_ovf_o`=1 and stays 1;
  - `pad_ack_o` toggles 5 times.
- WRITE ×2, then RUN, with ready delayed 5 cycles → `core_rst_o` falls only after the second write's handshake. `wb_rst_i` asserted mid-WRITE → `imem_valid_o`=0 and `core_rst_o`=1 immediately.
